// File: rtl/rs_enc_parity_gen.sv
// rs_enc_parity_gen: streaming Reed-Solomon (GF(256), poly 0x11D, alpha=0x02)
// parity generator. Passes N_DATA message bytes through, then appends four
// parity bytes from g(x) = (x+1)(x+a)(x+a^2)(x+a^3).
// Optional macro CD_PARITY_INVERT_EN: parity bytes are inverted (XOR 0xFF) on
// output only; the LFSR registers and the data bytes are unaffected.
module rs_enc_parity_gen #(
  parameter int N_DATA = 28
) (
  input  logic       i_clk,
  input  logic       i_resb,
  input  logic       i_frame_sync,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  input  logic       i_data_ready,
  output logic       o_last,
  output logic       o_abort
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;

  localparam logic [7:0] N_LAST = 8'(N_DATA);

`ifdef CD_PARITY_INVERT_EN
  localparam logic [7:0] PAR_MASK = 8'hFF;
`else
  localparam logic [7:0] PAR_MASK = 8'h00;
`endif

  // GF(256) multiply; with a constant operand this folds to an XOR network
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt, cnt_inc;
  logic [1:0] par_idx, par_idx_nxt;
  logic [7:0] r0, r1, r2, r3;
  logic [7:0] r0_nxt, r1_nxt, r2_nxt, r3_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, last_nxt, abort_nxt;
  logic       free, accept, restart;
  logic [7:0] fb, r0_base, r1_base, r2_base;

  // Next-state, handshake and LFSR update; a sync byte restarts the LFSR from zero
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    par_idx_nxt = par_idx;
    r0_nxt      = r0;
    r1_nxt      = r1;
    r2_nxt      = r2;
    r3_nxt      = r3;
    data_nxt    = o_data;
    valid_nxt   = o_data_valid;
    last_nxt    = o_last;
    abort_nxt   = 1'b0;

    free         = !o_data_valid || i_data_ready;
    o_data_ready = (state != S_PAR) && free;
    accept       = i_data_valid && o_data_ready;
    restart      = accept && i_frame_sync;
    cnt_inc      = restart ? 8'd1 : cnt + 8'd1;
    fb           = i_data ^ (restart ? 8'h00 : r3);
    r0_base      = restart ? 8'h00 : r0;
    r1_base      = restart ? 8'h00 : r1;
    r2_base      = restart ? 8'h00 : r2;

    if (free) begin
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
    end

    case (state)
      S_IDLE, S_DATA: begin
        if (accept && (restart || state == S_DATA)) begin
          r3_nxt    = r2_base ^ gf_mul(fb, 8'h0F);
          r2_nxt    = r1_base ^ gf_mul(fb, 8'h36);
          r1_nxt    = r0_base ^ gf_mul(fb, 8'h78);
          r0_nxt    = gf_mul(fb, 8'h40);
          cnt_nxt   = cnt_inc;
          data_nxt  = i_data;
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
          abort_nxt = restart && (state == S_DATA);
          state_nxt = (cnt_inc == N_LAST) ? S_PAR : S_DATA;
        end
      end
      S_PAR: begin
        if (free) begin
          data_nxt    = r3 ^ PAR_MASK;
          valid_nxt   = 1'b1;
          last_nxt    = (par_idx == 2'd3);
          r3_nxt      = r2;
          r2_nxt      = r1;
          r1_nxt      = r0;
          r0_nxt      = 8'h00;
          par_idx_nxt = par_idx + 2'd1;
          if (par_idx == 2'd3) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, LFSR and registered output slot; reset discards any partial frame
  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      state        <= S_IDLE;
      cnt          <= 8'd0;
      par_idx      <= 2'd0;
      r0           <= 8'h00;
      r1           <= 8'h00;
      r2           <= 8'h00;
      r3           <= 8'h00;
      o_data       <= 8'h00;
      o_data_valid <= 1'b0;
      o_last       <= 1'b0;
      o_abort      <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      par_idx      <= par_idx_nxt;
      r0           <= r0_nxt;
      r1           <= r1_nxt;
      r2           <= r2_nxt;
      r3           <= r3_nxt;
      o_data       <= data_nxt;
      o_data_valid <= valid_nxt;
      o_last       <= last_nxt;
      o_abort      <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_rs_enc_parity_gen.sv
// tb_rs_enc_parity_gen: scoreboard bench for rs_enc_parity_gen (N_DATA=28).
// Stimulus pushes expected bytes into a queue; a monitor pops and compares on
// every output transfer and also checks the codeword syndromes S0..S3 = 0.
module tb_rs_enc_parity_gen;
  localparam int N = 28;

`ifdef CD_PARITY_INVERT_EN
  localparam logic [7:0] PMASK = 8'hFF;
`else
  localparam logic [7:0] PMASK = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       resb = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready = 1'b1;
  logic       o_data_ready;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_last;
  logic       o_abort;

  int         checks = 0;
  int         errors = 0;
  int         abort_cnt = 0;
  bit         stall_en = 1'b0;
  logic [9:0] exp_q[$];
  logic [7:0] msg[0:255];
  logic [7:0] par[0:3];
  logic [7:0] syn[0:3];
  logic [7:0] apow[0:3];
  logic [9:0] held;
  bit         held_v;

  always #5 clk = ~clk;

  rs_enc_parity_gen #(.N_DATA(N)) dut (
    .i_clk(clk),
    .i_resb(resb),
    .i_frame_sync(frame_sync),
    .i_data(data),
    .i_data_valid(data_valid),
    .o_data_ready(o_data_ready),
    .o_data(o_data),
    .o_data_valid(o_data_valid),
    .i_data_ready(data_ready),
    .o_last(o_last),
    .o_abort(o_abort)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  task automatic check_val(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops on each transfer, checks hold-under-stall and syndromes
  initial begin
    apow[0] = 8'h01; apow[1] = 8'h02; apow[2] = 8'h04; apow[3] = 8'h08;
    for (int j = 0; j < 4; j++) syn[j] = 8'h00;
    held_v = 1'b0;
    held   = 10'h0;
    forever begin
      @(negedge clk);
      if (!resb) begin
        for (int j = 0; j < 4; j++) syn[j] = 8'h00;
        held_v = 1'b0;
      end else begin
        if (held_v) check_val("stall_hold", {o_data_valid, o_last, o_data}, held);
        held_v = o_data_valid && !data_ready;
        held   = {o_data_valid, o_last, o_data};
        if (o_abort) begin
          abort_cnt++;
          for (int j = 0; j < 4; j++) syn[j] = 8'h00;
        end
        if (o_data_valid && data_ready) begin
          logic [9:0] e;
          logic [7:0] c;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output at %0t", o_data, $time);
            c = o_data;
          end else begin
            e = exp_q.pop_front();
            check_val("out_byte", {o_last, o_data}, {23'd0, e[8:0]});
            c = e[9] ? (o_data ^ PMASK) : o_data;
          end
          for (int j = 0; j < 4; j++) syn[j] = gmul(syn[j], apow[j]) ^ c;
          if (o_last) begin
            for (int j = 0; j < 4; j++) begin
              check_val($sformatf("syndrome_S%0d", j), syn[j], 8'h00);
              syn[j] = 8'h00;
            end
          end
        end
      end
    end
  end

  // Downstream ready: toggles every cycle while stall_en is set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      data_ready = stall_en ? ~data_ready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] d, input bit sync, input bit push);
    int  t;
    bit  ok;
    t  = 0;
    ok = 1'b0;
    data = d;
    frame_sync = sync;
    data_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = o_data_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 500);
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got ready=0, expected ready=1");
    end else if (push) begin
      exp_q.push_back({2'b00, d});
    end
    data_valid = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send_byte(msg[i], (i == 0), 1'b1);
  endtask

  task automatic push_parity(input logic [7:0] p3, input logic [7:0] p2,
                             input logic [7:0] p1, input logic [7:0] p0);
    exp_q.push_back({2'b10, p3 ^ PMASK});
    exp_q.push_back({2'b10, p2 ^ PMASK});
    exp_q.push_back({2'b10, p1 ^ PMASK});
    exp_q.push_back({2'b11, p0 ^ PMASK});
  endtask

  // Reference parity: remainder of m(x)*x^4 by long division with g(x)
  task automatic model_parity(input int n);
    logic [7:0] c[0:259];
    logic [7:0] q;
    for (int i = 0; i < n + 4; i++) c[i] = (i < n) ? msg[i] : 8'h00;
    for (int i = 0; i < n; i++) begin
      q = c[i];
      c[i]     = 8'h00;
      c[i + 1] = c[i + 1] ^ gmul(q, 8'h0F);
      c[i + 2] = c[i + 2] ^ gmul(q, 8'h36);
      c[i + 3] = c[i + 3] ^ gmul(q, 8'h78);
      c[i + 4] = c[i + 4] ^ gmul(q, 8'h40);
    end
    for (int k = 0; k < 4; k++) par[k] = c[n + k];
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic set_unit_msg();
    for (int i = 0; i < N; i++) msg[i] = 8'h00;
    msg[N - 1] = 8'h01;
  endtask

  initial begin
    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_data", o_data, 8'h00);
    check_val("reset_valid", o_data_valid, 1'b0);
    check_val("reset_last", o_last, 1'b0);
    check_val("reset_abort", o_abort, 1'b0);
    @(negedge clk);
    resb = 1'b1;
    @(posedge clk);
    #1;

    // Bytes without sync in idle are dropped
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);

    // Back-to-back: all-zero frame, then unit frame (last byte 0x01)
    $display("[TB] zero frame then unit frame");
    for (int i = 0; i < N; i++) msg[i] = 8'h00;
    send_frame(N);
    push_parity(8'h00, 8'h00, 8'h00, 8'h00);
    set_unit_msg();
    send_frame(N);
    push_parity(8'h0F, 8'h36, 8'h78, 8'h40);
    wait_drain();

    // Random frames checked against the division model and syndromes
    $display("[TB] random frames");
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) msg[i] = 8'($urandom_range(0, 255));
      send_frame(N);
      model_parity(N);
      push_parity(par[0], par[1], par[2], par[3]);
    end
    wait_drain();

    // Stalled downstream: same unit-frame sequence, stable while stalled
    $display("[TB] stalled unit frame");
    stall_en = 1'b1;
    set_unit_msg();
    send_frame(N);
    push_parity(8'h0F, 8'h36, 8'h78, 8'h40);
    wait_drain();
    stall_en = 1'b0;
    wait_drain();

    // Restart at byte 10: nine old bytes stay emitted, new frame encodes
    $display("[TB] mid-frame restart");
    for (int i = 0; i < 9; i++) send_byte(8'(8'h11 * (i + 1)), (i == 0), 1'b1);
    set_unit_msg();
    send_frame(N);
    push_parity(8'h0F, 8'h36, 8'h78, 8'h40);
    wait_drain();
    check_val("abort_count", abort_cnt, 1);

    // Reset during parity phase, then a fresh synced frame
    $display("[TB] reset during parity");
    for (int i = 0; i < N; i++) msg[i] = 8'($urandom_range(0, 255));
    send_frame(N);
    model_parity(N);
    push_parity(par[0], par[1], par[2], par[3]);
    @(posedge clk);
    @(posedge clk);
    #1;
    resb = 1'b0;
    #1;
    check_val("rst_mid_data", o_data, 8'h00);
    check_val("rst_mid_valid", o_data_valid, 1'b0);
    check_val("rst_mid_last", o_last, 1'b0);
    exp_q.delete();
    @(negedge clk);
    resb = 1'b1;
    @(posedge clk);
    #1;
    set_unit_msg();
    send_frame(N);
    push_parity(8'h0F, 8'h36, 8'h78, 8'h40);
    wait_drain();
    check_val("abort_count_final", abort_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
